indication_output_queue: RTL and testbench
==========================================

# indication_output_queue

Parametrised successor to the two-entry even/odd indication serializer: accepts indication calls from NCHAN source methods, packs each into a 96-bit tagged message, and buffers it in a DEPTH-entry FIFO. The FIFO drains in order onto a single pipe enq port. It sits between a user indication interface and the pipe/transport side of a Connect-style top level, replacing fixed ping-pong buffering with configurable depth and channel count.

## Interface

Parameters:
- NCHAN, 2: number of indication source methods; tag values are 1..NCHAN.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CW, $clog2(DEPTH+1): width of the occupancy output.

Ports:
- CLK  in  1  clock; all state updates on the posedge.
- nRST  in  1  reset, synchronous, active-low.
- indication__ENA  in  NCHAN  per-channel call strobe; bit i is asserted only while indication__RDY[i] is high.
- indication$meth  in  32*NCHAN  per-channel meth argument; channel i occupies bits [32i+31:32i].
- indication$v  in  32*NCHAN  per-channel v argument; same packing as indication$meth.
- indication__RDY  out  NCHAN  per-channel ready.
- pipe$enq__ENA  out  1  pipe enq strobe.
- pipe$enq$v  out  96  packed message: [31:0] tag, [63:32] meth, [95:64] v.
- pipe$enq__RDY  in  1  downstream ready.
- count  out  CW  current FIFO occupancy, 0..DEPTH.

## Operation

- State:
  - storage array of DEPTH×96;
  - read pointer rd and write pointer wr, each log2(DEPTH) bits; both wrap modulo DEPTH;
  - occupancy counter cnt, CW bits.
  - full = (cnt == DEPTH); empty = (cnt == 0).
- Accept (push):
  - indication__RDY[i] = !full & !(|indication__ENA[i-1:0]). This is a fixed-priority grant: the lowest-indexed asserted channel wins.
  - At most one push occurs per cycle. When any ENA bit is granted:
    - storage[wr] <= {v_i, meth_i, 32'(i+1)};
    - wr <= wr + 1.
  - Higher-indexed channels that see RDY low must hold their call; protocol forbids ENA without RDY, so no data is lost.
- Drain (pop):
  - pipe$enq__ENA = !empty & pipe$enq__RDY.
  - pipe$enq$v = storage[rd] whenever !empty. It is 0 when empty.
  - On pipe$enq__ENA, rd <= rd + 1.
- Counter update:
  - push only: cnt+1;
  - pop only: cnt-1;
  - push and pop together: unchanged.
- Full: no channel is ready, even if a pop occurs in the same cycle (no full-bypass). A pop makes RDY high on the next cycle.
- Empty: no output. There is no write-through to pipe$enq$v in the cycle of the push.
- Ordering: strict FIFO across all channels. Tag identifies the source channel.
- Reset (nRST low at a posedge): rd, wr, cnt <= 0. Storage is not cleared. Any in-flight contents are discarded, including when reset is asserted mid-operation.

## Timing

- Reset values:
  - pipe$enq__ENA = 0;
  - pipe$enq$v = 0;
  - count = 0;
  - indication__RDY = all ones, for channels with no lower ENA asserted.
- Latency: a push in cycle t becomes visible on pipe$enq$v in cycle t+1, provided the FIFO was empty. pipe$enq__ENA is high in t+1 if pipe$enq__RDY is high.
- Throughput: one push and one pop per cycle sustained.
- Combinational paths:
  - indication__ENA → indication__RDY (priority chain);
  - pipe$enq__RDY → pipe$enq__ENA.
  - No path exists from indication inputs to pipe outputs.
- count reflects the registered cnt and updates at the edge.

## Test plan

- Single call, NCHAN=2, DEPTH=4:
  - Stimulus: ch1 meth=7, v=0x55 with pipe$enq__RDY=1.
  - Required: next cycle pipe$enq__ENA=1 and pipe$enq$v={0x55,7,2}; count goes 1→0.
- Fill to full:
  - Stimulus: 4 pushes on ch0 (v=1..4) with pipe$enq__RDY=0.
  - Required: count=4, indication__RDY=00.
  - Then raise pipe$enq__RDY: outputs v=1,2,3,4 in order with tag=1; RDY returns 11 the cycle after the first pop.
- Simultaneous calls:
  - Stimulus: ENA=11 in the same cycle.
  - Required: RDY[1]=0 that cycle and only the ch0 message enters. Ch1 holds and enters the next cycle; output tags are 1 then 2.
- Concurrent push/pop:
  - Stimulus: at count=2, push and pop in the same cycle.
  - Required: count stays 2; pointer wrap is verified over 10 such cycles with data order intact.
- Full with simultaneous pop:
  - Stimulus: count=4, pipe$enq__RDY=1, ENA asserted.
  - Required: RDY=0 and no push; count=3; push accepted the next cycle.
- Reset mid-stream:
  - Stimulus: nRST low with count=3.
  - Required: next cycle count=0, pipe$enq__ENA=0, pipe$enq$v=0; the first post-reset push is output as the sole message.

Source files
------------

// File: rtl/indication_output_queue.sv
// Indication serializer: fixed-priority accept from NCHAN sources into a DEPTH-entry
// FIFO of 96-bit tagged messages, drained in order onto a single pipe enq port.
module indication_output_queue #(
  parameter int NCHAN = 2,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NCHAN-1:0]      indication__ENA,
  input  logic [32*NCHAN-1:0]   indication_meth,
  input  logic [32*NCHAN-1:0]   indication_v,
  output logic [NCHAN-1:0]      indication__RDY,
  output logic                  pipe_enq__ENA,
  output logic [95:0]           pipe_enq_v,
  input  logic                  pipe_enq__RDY,
  output logic [CW-1:0]         count
);

  localparam int AW = $clog2(DEPTH);

  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          blocked;
  logic [95:0]   wr_data;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Any asserted lower channel blocks every higher one, whether or not it wins.
  always_comb begin
    blocked         = 1'b0;
    push            = 1'b0;
    wr_data         = '0;
    indication__RDY = '0;
    for (int i = 0; i < NCHAN; i++) begin
      indication__RDY[i] = !full && !blocked;
      if (indication__ENA[i] && !blocked && !full) begin
        push    = 1'b1;
        wr_data = {indication_v[32*i +: 32], indication_meth[32*i +: 32], 32'(i + 1)};
      end
      blocked = blocked | indication__ENA[i];
    end
  end

  assign pop           = !empty && pipe_enq__RDY;
  assign pipe_enq__ENA = pop;
  assign pipe_enq_v    = empty ? '0 : mem_q[rd_q];
  assign count         = cnt_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    if (push) begin
      wr_d = wr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is deliberately left uncleared; empty masks stale entries on the output.
  always_ff @(posedge CLK) begin
    if (nRST && push) begin
      mem_q[wr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_indication_output_queue.sv
// Bench for indication_output_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_indication_output_queue;

  localparam int NCHAN = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                CLK = 1'b0;
  logic                nRST = 1'b0;
  logic [NCHAN-1:0]    ind_ena;
  logic [32*NCHAN-1:0] ind_meth;
  logic [32*NCHAN-1:0] ind_v;
  logic [NCHAN-1:0]    ind_rdy;
  logic                pipe_ena;
  logic [95:0]         pipe_v;
  logic                pipe_rdy = 1'b0;
  logic [CW-1:0]       count;

  logic [NCHAN-1:0]    pend = '0;
  logic [31:0]         pm [NCHAN];
  logic [31:0]         pv [NCHAN];

  logic [95:0]         mq [$];
  int                  model_grant = -1;
  bit                  armed = 0;
  int                  tests = 0;
  int                  fails = 0;

  indication_output_queue #(.NCHAN(NCHAN), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .indication__ENA (ind_ena),
    .indication_meth (ind_meth),
    .indication_v    (ind_v),
    .indication__RDY (ind_rdy),
    .pipe_enq__ENA   (pipe_ena),
    .pipe_enq_v      (pipe_v),
    .pipe_enq__RDY   (pipe_rdy),
    .count           (count)
  );

  always #5 CLK = ~CLK;

  assign ind_ena = pend;

  always_comb begin
    ind_meth = '0;
    ind_v    = '0;
    for (int i = 0; i < NCHAN; i++) begin
      ind_meth[32*i +: 32] = pm[i];
      ind_v[32*i +: 32]    = pv[i];
    end
  end

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A source holds its call until the model says it was taken.
  task automatic applyStimulus(input int ch, input logic [31:0] m, input logic [31:0] vv);
    pend[ch] = 1'b1;
    pm[ch]   = m;
    pv[ch]   = vv;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (model_grant >= 0) pend[model_grant] = 1'b0;
  endtask

  // Reference model: outputs follow from queue contents, then the queue advances.
  always @(negedge CLK) begin : model
    int               first;
    bit               full;
    logic [NCHAN-1:0] exp_rdy;
    full  = (mq.size() == DEPTH);
    first = -1;
    for (int i = 0; i < NCHAN; i++)
      if (ind_ena[i] && first < 0) first = i;
    for (int i = 0; i < NCHAN; i++)
      exp_rdy[i] = !full && (first < 0 || first >= i);
    if (armed) begin
      checkOutput("rdy", 96'(ind_rdy), 96'(exp_rdy));
      checkOutput("pipe_ena", 96'(pipe_ena), 96'(mq.size() > 0 && pipe_rdy));
      checkOutput("pipe_v", pipe_v, (mq.size() > 0) ? mq[0] : 96'h0);
      checkOutput("count", 96'(count), 96'(mq.size()));
    end
    model_grant = -1;
    if (!nRST) begin
      mq.delete();
      armed = 1;
    end else begin
      if (mq.size() > 0 && pipe_rdy) void'(mq.pop_front());
      if (!full && first >= 0) begin
        mq.push_back({pv[first], pm[first], 32'(first + 1)});
        model_grant = first;
      end
    end
  end

  initial begin
    for (int i = 0; i < NCHAN; i++) begin
      pm[i] = '0;
      pv[i] = '0;
    end

    // Reset state
    nRST = 1'b0;
    step();
    step();
    checkOutput("reset_count", 96'(count), 96'd0);
    checkOutput("reset_ena", 96'(pipe_ena), 96'd0);
    checkOutput("reset_v", pipe_v, 96'd0);
    checkOutput("reset_rdy", 96'(ind_rdy), 96'b11);
    nRST = 1'b1;
    step();

    // Single call on ch1
    pipe_rdy = 1'b1;
    applyStimulus(1, 32'd7, 32'h55);
    step();
    checkOutput("single_ena", 96'(pipe_ena), 96'd1);
    checkOutput("single_v", pipe_v, {32'h55, 32'd7, 32'd2});
    checkOutput("single_count1", 96'(count), 96'd1);
    step();
    checkOutput("single_count0", 96'(count), 96'd0);

    // Fill to full on ch0, then drain
    pipe_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 32'hA0 + k, k);
      step();
    end
    checkOutput("full_count", 96'(count), 96'd4);
    checkOutput("full_rdy", 96'(ind_rdy), 96'b00);
    checkOutput("full_head", pipe_v, {32'd1, 32'hA1, 32'd1});
    pipe_rdy = 1'b1;
    step();
    checkOutput("drain_count", 96'(count), 96'd3);
    checkOutput("drain_rdy", 96'(ind_rdy), 96'b11);
    checkOutput("drain_head_v", 96'(pipe_v[95:64]), 96'd2);
    for (int k = 0; k < 3; k++) step();
    checkOutput("drain_empty", 96'(count), 96'd0);

    // Simultaneous calls
    pipe_rdy = 1'b0;
    applyStimulus(0, 32'h10, 32'h11);
    applyStimulus(1, 32'h20, 32'h21);
    #1;
    checkOutput("simul_rdy", 96'(ind_rdy), 96'b01);
    step();
    checkOutput("simul_count1", 96'(count), 96'd1);
    step();
    checkOutput("simul_count2", 96'(count), 96'd2);
    checkOutput("simul_tag1", 96'(pipe_v[31:0]), 96'd1);
    pipe_rdy = 1'b1;
    step();
    checkOutput("simul_tag2", 96'(pipe_v[31:0]), 96'd2);
    step();

    // Concurrent push/pop at count=2, wrapping pointers
    pipe_rdy = 1'b0;
    applyStimulus(0, 32'h300, 32'h400);
    step();
    applyStimulus(0, 32'h301, 32'h401);
    step();
    pipe_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 32'h310 + k, 32'h410 + k);
      step();
      checkOutput("concurrent_count", 96'(count), 96'd2);
    end
    step();
    step();

    // Full with simultaneous pop: no bypass
    pipe_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 32'h500 + k, 32'h600 + k);
      step();
    end
    pipe_rdy = 1'b1;
    applyStimulus(1, 32'h77, 32'h88);
    #1;
    checkOutput("fullpop_rdy", 96'(ind_rdy), 96'b00);
    step();
    checkOutput("fullpop_count3", 96'(count), 96'd3);
    step();
    checkOutput("fullpop_push", 96'(count), 96'd3);
    for (int k = 0; k < 4; k++) step();

    // Reset mid-stream
    pipe_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 32'h700 + k, 32'h800 + k);
      step();
    end
    checkOutput("midrst_count3", 96'(count), 96'd3);
    pipe_rdy = 1'b1;
    nRST = 1'b0;
    step();
    checkOutput("midrst_count", 96'(count), 96'd0);
    checkOutput("midrst_ena", 96'(pipe_ena), 96'd0);
    checkOutput("midrst_v", pipe_v, 96'd0);
    nRST = 1'b1;
    applyStimulus(0, 32'hAB, 32'hCD);
    step();
    checkOutput("postrst_v", pipe_v, {32'hCD, 32'hAB, 32'd1});
    checkOutput("postrst_count", 96'(count), 96'd1);
    step();
    checkOutput("postrst_empty", 96'(count), 96'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      pipe_rdy = ($urandom_range(0, 3) != 0);
      nRST     = ($urandom_range(0, 199) != 0);
      for (int ch = 0; ch < NCHAN; ch++)
        if (!pend[ch] && $urandom_range(0, 2) == 0)
          applyStimulus(ch, $urandom, $urandom);
      step();
    end
    nRST     = 1'b1;
    pipe_rdy = 1'b1;
    for (int c = 0; c < 20; c++) step();
    pend = '0;
    for (int c = 0; c < 8; c++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
